ddfs_sweep_ctrl: RTL and testbench

DDFS_SWEEP_CTRL -- requirements
Module: ddfs_sweep_ctrl

---
 rtl/ddfs_pkg.sv | 12 +
 rtl/ddfs_dwell_timer.sv | 25 ++
 rtl/ddfs_sweep_ctrl.sv | 130 +++++++++++++
 tb/tb_ddfs_sweep_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/ddfs_pkg.sv
// Shared definitions for the DDFS sweep controller: state encoding and default widths.
// Pure declarations, no logic.
package ddfs_pkg;
    localparam int FCW_WIDTH_DEF   = 32;
    localparam int DWELL_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DWELL = 2'd1,
        ST_LAST  = 2'd2
    } state_t;
endpackage

// File: rtl/ddfs_dwell_timer.sv
// Down-counter that reloads on i_load and reports expiry while at zero.
// Zero latency: o_expire is combinational from the count; no backpressure.
module ddfs_dwell_timer #(
    parameter int DWELL_WIDTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_load,
    input  logic [DWELL_WIDTH-1:0] i_value,
    output logic                   o_expire
);
    logic [DWELL_WIDTH-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expire = (r_cnt == '0);
endmodule

// File: rtl/ddfs_sweep_ctrl.sv
// Frequency sweep sequencer for a DDFS: steps o_freq_control from start to stop, holding each word dwell+1 cycles.
// Word updates one cycle after a decision; no backpressure. Define SWEEP_DOWN_EN to add i_dir (downward sweeps).
module ddfs_sweep_ctrl
    import ddfs_pkg::*;
#(
    parameter int FCW_WIDTH   = FCW_WIDTH_DEF,
    parameter int DWELL_WIDTH = DWELL_WIDTH_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic                   i_abort,
    input  logic [FCW_WIDTH-1:0]   i_start_fcw,
    input  logic [FCW_WIDTH-1:0]   i_stop_fcw,
    input  logic [FCW_WIDTH-1:0]   i_step_fcw,
    input  logic [DWELL_WIDTH-1:0] i_dwell,
    input  logic                   i_continuous,
`ifdef SWEEP_DOWN_EN
    input  logic                   i_dir,
`endif
    output logic [FCW_WIDTH-1:0]   o_freq_control,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_wrap
);
    state_t                 r_state;
    logic [FCW_WIDTH-1:0]   r_start, r_stop, r_step, r_freq;
    logic [DWELL_WIDTH-1:0] r_dwell;
    logic                   r_cont, r_done, r_wrap;

    logic                   w_accept, w_expire, w_load;
    logic [DWELL_WIDTH-1:0] w_value;
    logic [FCW_WIDTH:0]     w_sum;
    logic [FCW_WIDTH-1:0]   w_next;
    logic                   w_clamp, w_degen_in, w_degen_lat;

    assign w_accept = (r_state == ST_IDLE) && i_start && !i_abort;
    assign w_sum    = {1'b0, r_freq} + {1'b0, r_step};

`ifdef SWEEP_DOWN_EN
    logic               r_dir;
    logic [FCW_WIDTH:0] w_diff;
    assign w_diff      = {1'b0, r_freq} - {1'b0, r_step};
    assign w_next      = r_dir ? w_diff[FCW_WIDTH-1:0] : w_sum[FCW_WIDTH-1:0];
    // MSB of the widened difference is the borrow
    assign w_clamp     = r_dir ? (w_diff[FCW_WIDTH] || (w_diff[FCW_WIDTH-1:0] <= r_stop))
                               : (w_sum[FCW_WIDTH]  || (w_sum[FCW_WIDTH-1:0]  >= r_stop));
    assign w_degen_in  = i_dir ? (i_start_fcw <= i_stop_fcw) : (i_start_fcw >= i_stop_fcw);
    assign w_degen_lat = r_dir ? (r_start <= r_stop) : (r_start >= r_stop);
`else
    assign w_next      = w_sum[FCW_WIDTH-1:0];
    assign w_clamp     = w_sum[FCW_WIDTH] || (w_sum[FCW_WIDTH-1:0] >= r_stop);
    assign w_degen_in  = (i_start_fcw >= i_stop_fcw);
    assign w_degen_lat = (r_start >= r_stop);
`endif

    assign w_load  = w_accept || (w_expire && (r_state != ST_IDLE) && !i_abort);
    assign w_value = w_accept ? i_dwell : r_dwell;

    ddfs_dwell_timer #(.DWELL_WIDTH(DWELL_WIDTH)) u_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   (w_load),
        .i_value  (w_value),
        .o_expire (w_expire)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_start <= '0;
            r_stop  <= '0;
            r_step  <= '0;
            r_dwell <= '0;
            r_cont  <= 1'b0;
            r_freq  <= '0;
            r_done  <= 1'b0;
            r_wrap  <= 1'b0;
`ifdef SWEEP_DOWN_EN
            r_dir   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            r_wrap <= 1'b0;
            if (i_abort) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: if (i_start) begin
                        r_start <= i_start_fcw;
                        r_stop  <= i_stop_fcw;
                        r_step  <= i_step_fcw;
                        r_dwell <= i_dwell;
                        r_cont  <= i_continuous;
`ifdef SWEEP_DOWN_EN
                        r_dir   <= i_dir;
`endif
                        r_freq  <= i_start_fcw;
                        // A zero step is a CW tone and must never reach LAST
                        r_state <= (w_degen_in && (i_step_fcw != '0)) ? ST_LAST : ST_DWELL;
                    end
                    ST_DWELL: if (w_expire && (r_step != '0)) begin
                        if (w_clamp) begin
                            r_freq  <= r_stop;
                            r_state <= ST_LAST;
                        end else begin
                            r_freq  <= w_next;
                        end
                    end
                    ST_LAST: if (w_expire) begin
                        if (r_cont) begin
                            r_freq  <= r_start;
                            r_wrap  <= 1'b1;
                            r_state <= w_degen_lat ? ST_LAST : ST_DWELL;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign o_freq_control = r_freq;
    assign o_busy         = (r_state != ST_IDLE);
    assign o_done         = r_done;
    assign o_wrap         = r_wrap;
endmodule

// File: tb/tb_ddfs_sweep_ctrl.sv
// Directed and randomized sweeps of ddfs_sweep_ctrl checked against a word-list model built from the sweep rules.
module tb_ddfs_sweep_ctrl;
    logic        clk = 1'b0;
    logic        rst, start, abort, cont;
    logic [31:0] sfcw, pfcw, stfcw;
    logic [15:0] dwell;
    logic [31:0] freq;
    logic        busy, done, wrap;

    int checks   = 0;
    int failures = 0;
    longint words[$];

    ddfs_sweep_ctrl #(.FCW_WIDTH(32), .DWELL_WIDTH(16)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .i_abort        (abort),
        .i_start_fcw    (sfcw),
        .i_stop_fcw     (pfcw),
        .i_step_fcw     (stfcw),
        .i_dwell        (dwell),
        .i_continuous   (cont),
        .o_freq_control (freq),
        .o_busy         (busy),
        .o_done         (done),
        .o_wrap         (wrap)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input longint ew, input logic eb, input logic ed, input logic ewr);
        chk({tag, ".word"}, {32'd0, freq}, ew);
        chk({tag, ".busy"}, {63'd0, busy}, {63'd0, eb});
        chk({tag, ".done"}, {63'd0, done}, {63'd0, ed});
        chk({tag, ".wrap"}, {63'd0, wrap}, {63'd0, ewr});
    endtask

    // Inputs other than abort/reset are don't-care while busy; perturb them
    task automatic scramble();
        sfcw  = $urandom;
        pfcw  = $urandom;
        stfcw = $urandom;
        dwell = 16'($urandom);
        cont  = 1'($urandom_range(0, 1));
        start = 1'($urandom_range(0, 1));
    endtask

    // Expected list of words of one upward pass
    task automatic build(input longint s, input longint p, input longint st);
        longint w;
        words.delete();
        if (st == 0 || s >= p) begin
            words.push_back(s);
        end else begin
            w = s;
            while (w < p) begin
                words.push_back(w);
                w = w + st;
            end
            words.push_back(p);
        end
    endtask

    task automatic launch(input longint s, input longint p, input longint st, input int d, input logic c);
        sfcw  = s[31:0];
        pfcw  = p[31:0];
        stfcw = st[31:0];
        dwell = d[15:0];
        cont  = c;
        start = 1'b1;
        tick();
    endtask

    // Runs reps passes; single sweeps also check the completion pulse
    task automatic run_sweep(input string tag, input longint s, input longint p, input longint st,
                             input int d, input logic c, input int reps);
        build(s, p, st);
        launch(s, p, st, d, c);
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < words.size(); i++) begin
                for (int k = 0; k <= d; k++) begin
                    chk_out(tag, words[i], 1'b1, 1'b0, (r > 0 && i == 0 && k == 0));
                    if (!c && i == words.size() - 1 && k == d) start = 1'b0;
                    else scramble();
                    tick();
                end
            end
        end
        if (!c) begin
            chk_out({tag, ".end"}, words[words.size()-1], 1'b0, 1'b1, 1'b0);
            tick();
            chk_out({tag, ".post"}, words[words.size()-1], 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        longint s, p, st;
        rst = 1'b1; start = 1'b0; abort = 1'b0; cont = 1'b0;
        sfcw = '0; pfcw = '0; stfcw = '0; dwell = '0;
        tick();
        tick();
        chk_out("reset", 0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        chk_out("idle", 0, 1'b0, 1'b0, 1'b0);

        run_sweep("basic", 100, 400, 100, 2, 1'b0, 1);
        run_sweep("clamp", 100, 350, 100, 0, 1'b0, 1);
        run_sweep("carry", 64'hFFFFFF00, 64'hFFFFFFFF, 64'h200, 1, 1'b0, 1);
        run_sweep("degen", 500, 200, 10, 1, 1'b0, 1);

        // Continuous sweep, then abort in the middle of the start word's dwell
        run_sweep("cont", 10, 30, 10, 1, 1'b1, 2);
        chk_out("cont.wrap", 10, 1'b1, 1'b0, 1'b1);
        scramble();
        tick();
        chk_out("cont.mid", 10, 1'b1, 1'b0, 1'b0);
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_out("abort", 10, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("abort.hold", 10, 1'b0, 1'b0, 1'b0);

        // Zero step: CW tone until abort
        launch(5, 100, 0, int'($urandom_range(0, 3)), 1'b0);
        for (int n = 0; n < 1000; n++) begin
            chk("cw.word", {32'd0, freq}, 64'd5);
            chk("cw.busy", {63'd0, busy}, 64'd1);
            scramble();
            tick();
        end
        start = 1'b1;
        abort = 1'b1;
        tick();
        chk_out("cw.abort", 5, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("idle.startabort", 5, 1'b0, 1'b0, 1'b0);
        start = 1'b0;
        abort = 1'b0;

        for (int t = 0; t < 6; t++) begin
            s  = longint'($urandom_range(0, 1000));
            p  = s + longint'($urandom_range(1, 1000));
            st = longint'($urandom_range(20, 400));
            run_sweep("rand", s, p, st, int'($urandom_range(0, 3)), 1'b0, 1);
        end

        // Reset in the middle of a dwell
        launch(1000, 5000, 7, 3, 1'b0);
        start = 1'b0;
        tick();
        tick();
        chk_out("pre_rst", 1000, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        chk_out("mid_rst", 0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        chk_out("post_rst", 0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
